// File: rtl/sim_range_gen.sv
// Purpose: turns an asynchronous radar PRT trigger into a stepped 10-bit range code, one sweep per trigger.
// Latency: range_valid rises SYNC_STAGES+1 clk after trig rises at the synchroniser input; all outputs registered.
// Backpressure: none; free-running sweep. A retrigger mid-sweep restarts it (enable=1) and always flags trig_overrun.
//
// Ports:
//   clk          system clock
//   resset       asynchronous reset, active-low
//   trig         raw PRT trigger, asynchronous to clk, active-high
//   enable       1 = accept triggers; 0 = ignore new triggers (a running sweep still finishes)
//   bin_div      clk cycles per range bin minus 1 (sampled at sweep start)
//   max_range    last bin code of a sweep (sampled at sweep start)
//   range        current range code, IDLE_CODE while idle
//   range_valid  high while a sweep is active
//   sweep_done   1-clk pulse after the last bin of a sweep
//   trig_overrun 1-clk pulse when a trigger arrives mid-sweep
//   prt_count    sweeps started since reset, wraps
module sim_range_gen #(
  parameter logic [9:0] IDLE_CODE   = 10'h3FF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resset,
  input  logic        trig,
  input  logic        enable,
  input  logic [7:0]  bin_div,
  input  logic [9:0]  max_range,
  output logic [9:0]  range,
  output logic        range_valid,
  output logic        sweep_done,
  output logic        trig_overrun,
  output logic [15:0] prt_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   trig_prev;
  logic                   trig_sync;
  logic                   sync_primed;
  logic                   trig_rise;
  logic [7:0]             bin_cnt;
  logic [7:0]             sh_div;
  logic [9:0]             sh_max;

  assign trig_sync   = sync_q[SYNC_STAGES-1];
  assign sync_primed = fill_q[SYNC_STAGES-1];

  // fill_q tracks when the synchroniser output reflects a real post-reset
  // sample. Until then trig_prev is held high, so a trigger that is already
  // high when reset releases is not mistaken for a fresh rising edge; it must
  // be seen low before the next rise counts.
  always_ff @(posedge clk or negedge resset) begin
    if (!resset) begin
      sync_q    <= '0;
      fill_q    <= '0;
      trig_prev <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], trig};
      fill_q    <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      trig_prev <= sync_primed ? trig_sync : 1'b1;
    end
  end

  assign trig_rise = sync_primed & trig_sync & ~trig_prev;

  always_ff @(posedge clk or negedge resset) begin
    if (!resset) begin
      state        <= IDLE;
      range        <= IDLE_CODE;
      range_valid  <= 1'b0;
      sweep_done   <= 1'b0;
      trig_overrun <= 1'b0;
      prt_count    <= 16'd0;
      bin_cnt      <= 8'd0;
      sh_div       <= 8'd0;
      sh_max       <= 10'd0;
    end else begin
      sweep_done   <= 1'b0;
      trig_overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_rise && enable) begin
            state       <= SWEEP;
            range       <= 10'd0;
            range_valid <= 1'b1;
            bin_cnt     <= 8'd0;
            sh_div      <= bin_div;
            sh_max      <= max_range;
            prt_count   <= prt_count + 16'd1;
          end
        end
        SWEEP: begin
          // Any mid-sweep trigger is flagged; only an enabled one restarts,
          // and a restart takes priority over finishing the last bin.
          if (trig_rise) begin
            trig_overrun <= 1'b1;
          end
          if (trig_rise && enable) begin
            range     <= 10'd0;
            bin_cnt   <= 8'd0;
            sh_div    <= bin_div;
            sh_max    <= max_range;
            prt_count <= prt_count + 16'd1;
          end else if (bin_cnt == sh_div) begin
            bin_cnt <= 8'd0;
            if (range == sh_max) begin
              state       <= IDLE;
              range       <= IDLE_CODE;
              range_valid <= 1'b0;
              sweep_done  <= 1'b1;
            end else begin
              range <= range + 10'd1;
            end
          end else begin
            bin_cnt <= bin_cnt + 8'd1;
          end
        end
        default: begin
          state       <= IDLE;
          range       <= IDLE_CODE;
          range_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_range_gen.sv
module tb_sim_range_gen;

  logic        clk = 1'b0;
  logic        resset;
  logic        trig;
  logic        enable;
  logic [7:0]  bin_div;
  logic [9:0]  max_range;
  logic [9:0]  range;
  logic        range_valid;
  logic        sweep_done;
  logic        trig_overrun;
  logic [15:0] prt_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_prt  = 16'd0;

  always #5 clk = ~clk;

  sim_range_gen #(
    .IDLE_CODE  (10'h3FF),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .resset      (resset),
    .trig        (trig),
    .enable      (enable),
    .bin_div     (bin_div),
    .max_range   (max_range),
    .range       (range),
    .range_valid (range_valid),
    .sweep_done  (sweep_done),
    .trig_overrun(trig_overrun),
    .prt_count   (prt_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Raise trig for 2 clk; on return the first sweep cycle is visible.
  task automatic send_trig;
    trig = 1'b1;
    tick();
    tick();
    trig = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    resset = 1'b1; trig = 1'b0; enable = 1'b1; bin_div = 8'd0; max_range = 10'd0;
    #2 resset = 1'b0;
    #10;
    n_checks++;
    if ({range_valid, range, sweep_done, trig_overrun, prt_count} !== {1'b0, 10'h3FF, 1'b0, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b range=%h done=%b ovr=%b prt=%h, want 0/3ff/0/0/0",
               range_valid, range, sweep_done, trig_overrun, prt_count);
    end
    tick();
    resset = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_basic;
    bin_div = 8'd3; max_range = 10'd5; enable = 1'b1;
    trig = 1'b1;
    tick(); tick();
    n_checks++;
    if (range_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_latency_early: valid=%b want 0", range_valid);
    end
    trig = 1'b0;
    tick();
    exp_prt = exp_prt + 16'd1;
    n_checks++;
    if (range_valid !== 1'b1 || prt_count !== exp_prt) begin
      n_fail++; $display("FAIL basic_latency: valid=%b prt=%0d want 1/%0d", range_valid, prt_count, exp_prt);
    end
    for (int c = 0; c < 24; c++) begin
      n_checks++;
      if (range !== 10'(c / 4) || range_valid !== 1'b1 || sweep_done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_step c=%0d: range=%0d valid=%b done=%b want %0d/1/0", c, range, range_valid, sweep_done, c / 4);
        break;
      end
      tick();
    end
    n_checks++;
    if ({range_valid, range, sweep_done, prt_count} !== {1'b0, 10'h3FF, 1'b1, exp_prt}) begin
      n_fail++; $display("FAIL basic_end: valid=%b range=%h done=%b prt=%0d want 0/3ff/1/%0d",
                         range_valid, range, sweep_done, prt_count, exp_prt);
    end
    tick();
    n_checks++;
    if (sweep_done !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_width: done=%b want 0", sweep_done);
    end
    tick();
  endtask

  task automatic test_fast;
    bin_div = 8'd0; max_range = 10'd0;
    send_trig();
    exp_prt = exp_prt + 16'd1;
    n_checks++;
    if (range !== 10'd0 || range_valid !== 1'b1) begin
      n_fail++; $display("FAIL fast_single: range=%h valid=%b want 0/1", range, range_valid);
    end
    tick();
    n_checks++;
    if ({range_valid, range, sweep_done} !== {1'b0, 10'h3FF, 1'b1}) begin
      n_fail++; $display("FAIL fast_single_end: valid=%b range=%h done=%b want 0/3ff/1", range_valid, range, sweep_done);
    end
    tick(); tick();
    bin_div = 8'd0; max_range = 10'h3FF;
    send_trig();
    exp_prt = exp_prt + 16'd1;
    for (int i = 0; i < 1024; i++) begin
      n_checks++;
      if (range !== 10'(i) || range_valid !== 1'b1 || sweep_done !== 1'b0) begin
        n_fail++;
        $display("FAIL fast_full i=%0d: range=%0d valid=%b done=%b want %0d/1/0", i, range, range_valid, sweep_done, i);
        break;
      end
      tick();
    end
    n_checks++;
    if ({range_valid, range, sweep_done, prt_count} !== {1'b0, 10'h3FF, 1'b1, exp_prt}) begin
      n_fail++; $display("FAIL fast_full_end: valid=%b range=%h done=%b prt=%0d want 0/3ff/1/%0d",
                         range_valid, range, sweep_done, prt_count, exp_prt);
    end
    tick(); tick();
  endtask

  task automatic test_retrigger;
    int n_done;
    int done_at;
    n_done = 0; done_at = -1;
    bin_div = 8'd1; max_range = 10'd20;
    send_trig();
    exp_prt = exp_prt + 16'd1;
    for (int i = 0; i < 12; i++) tick();
    trig = 1'b1;
    tick(); tick();
    n_checks++;
    if (range !== 10'd7 || trig_overrun !== 1'b0) begin
      n_fail++; $display("FAIL retrig_pre: range=%0d ovr=%b want 7/0", range, trig_overrun);
    end
    trig = 1'b0;
    tick();
    exp_prt = exp_prt + 16'd1;
    n_checks++;
    if ({trig_overrun, range_valid, range, sweep_done, prt_count} !== {1'b1, 1'b1, 10'd0, 1'b0, exp_prt}) begin
      n_fail++; $display("FAIL retrig_restart: ovr=%b valid=%b range=%0d done=%b prt=%0d want 1/1/0/0/%0d",
                         trig_overrun, range_valid, range, sweep_done, prt_count, exp_prt);
    end
    tick();
    n_checks++;
    if (trig_overrun !== 1'b0 || range !== 10'd0) begin
      n_fail++; $display("FAIL retrig_ovr_width: ovr=%b range=%0d want 0/0", trig_overrun, range);
    end
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (sweep_done === 1'b1) begin
        n_done++;
        done_at = i;
      end
    end
    n_checks++;
    if (n_done != 1 || done_at != 41) begin
      n_fail++; $display("FAIL retrig_done: pulses=%0d at=%0d want 1 at 41", n_done, done_at);
    end
  endtask

  task automatic test_enable;
    enable = 1'b0; bin_div = 8'd0; max_range = 10'd2;
    for (int k = 0; k < 3; k++) begin
      send_trig();
      n_checks++;
      if (range_valid !== 1'b0 || trig_overrun !== 1'b0 || prt_count !== exp_prt) begin
        n_fail++; $display("FAIL enable_idle k=%0d: valid=%b ovr=%b prt=%0d want 0/0/%0d",
                           k, range_valid, trig_overrun, prt_count, exp_prt);
      end
      tick(); tick();
    end
    enable = 1'b1; bin_div = 8'd2; max_range = 10'd3;
    send_trig();
    exp_prt = exp_prt + 16'd1;
    tick(); tick();
    enable = 1'b0;
    trig = 1'b1;
    tick(); tick();
    trig = 1'b0;
    tick();
    n_checks++;
    if ({trig_overrun, range_valid, range, prt_count} !== {1'b1, 1'b1, 10'd1, exp_prt}) begin
      n_fail++; $display("FAIL enable_mid_ovr: ovr=%b valid=%b range=%0d prt=%0d want 1/1/1/%0d",
                         trig_overrun, range_valid, range, prt_count, exp_prt);
    end
    for (int c = 6; c < 12; c++) begin
      tick();
      n_checks++;
      if (range !== 10'(c / 3) || trig_overrun !== 1'b0 || sweep_done !== 1'b0) begin
        n_fail++; $display("FAIL enable_mid_step c=%0d: range=%0d ovr=%b done=%b want %0d/0/0",
                           c, range, trig_overrun, sweep_done, c / 3);
        break;
      end
    end
    tick();
    n_checks++;
    if ({range_valid, range, sweep_done} !== {1'b0, 10'h3FF, 1'b1}) begin
      n_fail++; $display("FAIL enable_mid_end: valid=%b range=%h done=%b want 0/3ff/1", range_valid, range, sweep_done);
    end
    enable = 1'b1;
    tick(); tick();
  endtask

  task automatic test_shadow;
    bin_div = 8'd3; max_range = 10'd5;
    send_trig();
    exp_prt = exp_prt + 16'd1;
    bin_div = 8'd10; max_range = 10'd2;
    for (int c = 0; c < 24; c++) begin
      n_checks++;
      if (range !== 10'(c / 4) || range_valid !== 1'b1) begin
        n_fail++; $display("FAIL shadow_cur c=%0d: range=%0d valid=%b want %0d/1", c, range, range_valid, c / 4);
        break;
      end
      tick();
    end
    n_checks++;
    if (sweep_done !== 1'b1 || range_valid !== 1'b0) begin
      n_fail++; $display("FAIL shadow_cur_end: done=%b valid=%b want 1/0", sweep_done, range_valid);
    end
    tick(); tick();
    send_trig();
    exp_prt = exp_prt + 16'd1;
    for (int c = 0; c < 33; c++) begin
      n_checks++;
      if (range !== 10'(c / 11) || range_valid !== 1'b1) begin
        n_fail++; $display("FAIL shadow_next c=%0d: range=%0d valid=%b want %0d/1", c, range, range_valid, c / 11);
        break;
      end
      tick();
    end
    n_checks++;
    if (sweep_done !== 1'b1 || range !== 10'h3FF || prt_count !== exp_prt) begin
      n_fail++; $display("FAIL shadow_next_end: done=%b range=%h prt=%0d want 1/3ff/%0d", sweep_done, range, prt_count, exp_prt);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid;
    bin_div = 8'd3; max_range = 10'd5;
    trig = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 16; i++) tick();
    n_checks++;
    if (range !== 10'd4) begin
      n_fail++; $display("FAIL rst_mid_pre: range=%0d want 4", range);
    end
    resset = 1'b0;
    #1;
    n_checks++;
    if ({range_valid, range, sweep_done, trig_overrun, prt_count} !== {1'b0, 10'h3FF, 1'b0, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL rst_mid_async: valid=%b range=%h done=%b ovr=%b prt=%0d want 0/3ff/0/0/0",
                         range_valid, range, sweep_done, trig_overrun, prt_count);
    end
    exp_prt = 16'd0;
    tick(); tick();
    resset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (range_valid !== 1'b0 || prt_count !== 16'd0) begin
        n_fail++; $display("FAIL rst_mid_held i=%0d: valid=%b prt=%0d want 0/0", i, range_valid, prt_count);
        break;
      end
    end
    trig = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (range_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_low: valid=%b want 0", range_valid);
    end
    send_trig();
    exp_prt = exp_prt + 16'd1;
    n_checks++;
    if (range_valid !== 1'b1 || range !== 10'd0 || prt_count !== exp_prt) begin
      n_fail++; $display("FAIL rst_mid_retrig: valid=%b range=%0d prt=%0d want 1/0/%0d", range_valid, range, prt_count, exp_prt);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_fast();
    test_retrigger();
    test_enable();
    test_shadow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
